// File: rtl/alu_operand_join.sv
// Operand join stage ahead of the ALU: two small operand FIFOs feed one registered
// valid/ready pair. Operand A may be held as a reused constant across fires.
module alu_operand_join #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             cfg_a_const,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_valid,
  input  logic             out_ready
);
  // Handshake: a beat transfers on the rising edge where valid && ready are both high;
  // a sender holds data and valid until that edge, and ready never depends on valid.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_a_d [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [WIDTH-1:0] mem_b_d [DEPTH];
  logic [PW-1:0]    wr_a_q, wr_a_d, rd_a_q, rd_a_d;
  logic [PW-1:0]    wr_b_q, wr_b_d, rd_b_q, rd_b_d;
  logic [CW-1:0]    count_a_q, count_a_d, count_b_q, count_b_d;
  logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic             out_valid_q, out_valid_d;
  logic             push_a, push_b, pop_a, pop_b, fire;

  // Ready is derived from registered counts only, so out_ready never reaches it.
  assign a_ready   = (count_a_q != FULL);
  assign b_ready   = (count_b_q != FULL);
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_valid = out_valid_q;

  always_comb begin
    push_a = a_valid && a_ready;
    push_b = b_valid && b_ready;
    fire   = (count_a_q != '0) && (count_b_q != '0) && (!out_valid_q || out_ready);
    pop_a  = fire && !cfg_a_const;
    pop_b  = fire;

    mem_a_d = mem_a_q;
    mem_b_d = mem_b_q;
    if (push_a) mem_a_d[wr_a_q] = a_data;
    if (push_b) mem_b_d[wr_b_q] = b_data;

    wr_a_d = push_a ? wr_a_q + PW'(1) : wr_a_q;
    wr_b_d = push_b ? wr_b_q + PW'(1) : wr_b_q;
    rd_a_d = pop_a  ? rd_a_q + PW'(1) : rd_a_q;
    rd_b_d = pop_b  ? rd_b_q + PW'(1) : rd_b_q;

    count_a_d = count_a_q + CW'(push_a) - CW'(pop_a);
    count_b_d = count_b_q + CW'(push_b) - CW'(pop_b);

    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_valid_d = out_valid_q;
    if (fire) begin
      out_a_d     = mem_a_q[rd_a_q];
      out_b_d     = mem_b_q[rd_b_q];
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_q[i] <= '0;
        mem_b_q[i] <= '0;
      end
      wr_a_q      <= '0;
      wr_b_q      <= '0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      count_a_q   <= '0;
      count_b_q   <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      mem_a_q     <= mem_a_d;
      mem_b_q     <= mem_b_d;
      wr_a_q      <= wr_a_d;
      wr_b_q      <= wr_b_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      count_a_q   <= count_a_d;
      count_b_q   <= count_b_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_alu_operand_join.sv
// Directed bench for alu_operand_join: join latency, streaming, backpressure,
// constant-A reuse, random-gap wrap-around and asynchronous reset.
module tb_alu_operand_join;
  localparam int W = 32;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a_data, b_data, out_a, out_b;
  logic         a_valid, a_ready, b_valid, b_ready;
  logic         cfg_a_const, out_valid, out_ready;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_exp;
  int n_vec = 0;
  int n_err = 0;
  bit wrap_done;

  always #5 clk = ~clk;

  alu_operand_join #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .cfg_a_const(cfg_a_const),
    .out_a(out_a), .out_b(out_b), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Scoreboard: every accepted output pair must match the head of exp_q.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra", 64'(out_valid), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_a", 64'(out_a), 64'(mon_exp[2*W-1:W]));
        check("sb_b", 64'(out_b), 64'(mon_exp[W-1:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_q.push_back({a, b});
  endtask

  task automatic send_a(input logic [W-1:0] v);
    logic acc;
    a_data  = v;
    a_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = a_ready;
      tick();
      if (acc) begin
        a_valid = 1'b0;
        return;
      end
    end
    a_valid = 1'b0;
    check("a_timeout", 64'd1, 64'd0);
  endtask

  task automatic send_b(input logic [W-1:0] v);
    logic acc;
    b_data  = v;
    b_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = b_ready;
      tick();
      if (acc) begin
        b_valid = 1'b0;
        return;
      end
    end
    b_valid = 1'b0;
    check("b_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) return;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    cfg_a_const = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_out_a", 64'(out_a), 64'd0);
    check("rst_out_b", 64'(out_b), 64'd0);
    check("rst_ready", 64'({a_ready, b_ready}), 64'd3);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Basic join: A in cycle 0, B in cycle 3, pair visible only in cycle 5.
    out_ready = 1'b1;
    exp_push(32'h11, 32'h22);
    a_data = 32'h11; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    b_data = 32'h22; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    @(negedge clk);
    check("join_c4_valid", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("join_c5_valid", 64'(out_valid), 64'd1);
    check("join_c5_a", 64'(out_a), 64'h11);
    check("join_c5_b", 64'(out_b), 64'h22);
    tick();
    @(negedge clk);
    check("join_c6_valid", 64'(out_valid), 64'd0);
    tick();

    // Streaming: eight pairs on consecutive cycles, readies never drop.
    for (int i = 1; i <= 8; i++) exp_push(W'(i), W'(100 + i));
    fork
      begin for (int i = 1; i <= 8; i++) send_a(W'(i)); end
      begin for (int i = 1; i <= 8; i++) send_b(W'(100 + i)); end
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check("stream_ready", 64'({a_ready, b_ready}), 64'd3);
          if (c >= 2) check("stream_valid", 64'(out_valid), 64'd1);
        end
      end
    join
    wait_drain();
    tick();

    // Backpressure: one pair held plus DEPTH per FIFO, then readies drop.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) exp_push(W'(32'h30 + i), W'(32'h40 + i));
    fork
      begin for (int i = 1; i <= 4; i++) send_a(W'(32'h30 + i)); end
      begin for (int i = 1; i <= 4; i++) send_b(W'(32'h40 + i)); end
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("bp_ready_open", 64'({a_ready, b_ready}), 64'd3);
        end
        for (int c = 3; c < 7; c++) begin
          @(negedge clk);
          check("bp_ready_full", 64'({a_ready, b_ready}), 64'd0);
          check("bp_hold_valid", 64'(out_valid), 64'd1);
          check("bp_hold_a", 64'(out_a), 64'h31);
          check("bp_hold_b", 64'(out_b), 64'h41);
        end
        tick();
        out_ready = 1'b1;
      end
    join
    wait_drain();
    tick();

    // Constant A: head reused while cfg_a_const is set, popped once cleared.
    cfg_a_const = 1'b1;
    exp_push(32'h5, 32'h1);
    exp_push(32'h5, 32'h2);
    exp_push(32'h5, 32'h3);
    send_a(32'h5);
    send_b(32'h1);
    send_b(32'h2);
    send_b(32'h3);
    wait_drain();
    check("const_count_a_1", 64'(dut.count_a_q), 64'd1);
    tick();
    cfg_a_const = 1'b0;
    exp_push(32'h5, 32'h4);
    send_b(32'h4);
    wait_drain();
    check("const_count_a_0", 64'(dut.count_a_q), 64'd0);
    tick();
    send_b(32'h7);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("const_a_empty_no_fire", 64'(out_valid), 64'd0);
      tick();
    end
    exp_push(32'h8, 32'h7);
    send_a(32'h8);
    wait_drain();
    tick();

    // Wrap-around with random gaps and random out_ready.
    for (int i = 0; i < 3 * D + 1; i++) exp_push(W'(32'h200 + i), W'(32'h300 + i));
    wrap_done = 1'b0;
    fork
      begin
        fork
          begin
            for (int i = 0; i < 3 * D + 1; i++) begin
              repeat ($urandom_range(0, 2)) tick();
              send_a(W'(32'h200 + i));
            end
          end
          begin
            for (int i = 0; i < 3 * D + 1; i++) begin
              repeat ($urandom_range(0, 2)) tick();
              send_b(W'(32'h300 + i));
            end
          end
        join
        wrap_done = 1'b1;
      end
      begin
        while (!wrap_done) begin
          tick();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        while (!wrap_done) begin
          @(negedge clk);
          if (dut.count_a_q == D) check("wrap_full_a_ready", 64'(a_ready), 64'd0);
          if (dut.count_b_q == D) check("wrap_full_b_ready", 64'(b_ready), 64'd0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    tick();

    // Asynchronous reset mid-cycle with both FIFOs holding two items and a pair held.
    out_ready = 1'b0;
    fork
      begin for (int i = 1; i <= 3; i++) send_a(W'(32'h60 + i)); end
      begin for (int i = 1; i <= 3; i++) send_b(W'(32'h70 + i)); end
    join
    check("pre_rst_ready", 64'({a_ready, b_ready}), 64'd0);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_a", 64'(out_a), 64'd0);
    check("async_rst_b", 64'(out_b), 64'd0);
    check("async_rst_ready", 64'({a_ready, b_ready}), 64'd3);
    tick();
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_idle", 64'(out_valid), 64'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
